// File: rtl/sdram_frame_pkg.sv
// sdram_frame_pkg: shared types and constants for the SDRAM frame reader.
//   pixel_t       - {B,G,R} pixel, 8 bits per channel
//   sdram_word_t  - one 16-bit SDRAM data word
//   sdram_laddr_t - linear word address split as {bank, row, col}
//   rd_state_e    - frame reader FSM states
package sdram_frame_pkg;

   localparam int BANK_W  = 2;
   localparam int ROW_W   = 13;
   localparam int COL_W   = 9;
   localparam int LADDR_W = BANK_W + ROW_W + COL_W;

   typedef logic [2:0][7:0] pixel_t;
   typedef logic [15:0]     sdram_word_t;

   typedef struct packed {
      logic [BANK_W-1:0] bank;
      logic [ROW_W-1:0]  row;
      logic [COL_W-1:0]  col;
   } sdram_laddr_t;

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN, ST_DONE} rd_state_e;

   // Word 0 = {G, R}, word 1 = {8'h00, B}; the upper byte of word 1 is unused.
   function automatic pixel_t make_pixel(input sdram_word_t w0, input sdram_word_t w1);
      return {w1[7:0], w0[15:8], w0[7:0]};
   endfunction

endpackage

// File: rtl/sdram_rd_fifo.sv
// sdram_rd_fifo: show-ahead pixel FIFO.
//   clk, rst_n      - clock, asynchronous active-low reset (empties the FIFO)
//   wr_en, wr_data  - push (ignored when full)
//   rd_en           - pop the head entry (ignored when empty)
//   rd_data         - head entry, valid whenever !empty; zero when empty
//   empty, full     - status
//   count           - number of stored entries
module sdram_rd_fifo
   import sdram_frame_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  pixel_t        wr_data,
   input  logic          rd_en,
   output pixel_t        rd_data,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   pixel_t        mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr_go, rd_go;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   // Gate the head to zero so an empty FIFO never shows stale or unwritten data.
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_go    = wr_en && !full;
      rd_go    = rd_en && !empty;
      wr_ptr_d = wr_go ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_go ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (wr_go && !rd_go)      count_d = count_q + CW'(1);
      else if (rd_go && !wr_go) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_go) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/sdram_frame_reader.sv
// sdram_frame_reader: fetches one frame from SDRAM with burst reads, rebuilds
// 24-bit pixels from 16-bit word pairs and streams them with valid/ready.
//   SDRAM_CLK, reset_n           - clock, asynchronous active-low reset
//   start, frame_base            - frame request and base word address
//   rd_req, rd_ack, SDRAM_*      - burst read request channel
//   rd_data_valid, rd_data       - returned words, one per cycle
//   pix_rgb/valid/ready/last     - pixel stream
//   busy, frame_done, overflow   - status
module sdram_frame_reader
   import sdram_frame_pkg::*;
#(
   parameter int FRAME_PIXELS = 16384,
   parameter int BURST_LEN    = 8,
   parameter int FIFO_DEPTH   = 32
) (
   input  logic               SDRAM_CLK,
   input  logic               reset_n,
   input  logic               start,
   input  logic [LADDR_W-1:0] frame_base,
   output logic               rd_req,
   input  logic               rd_ack,
   output logic [BANK_W-1:0]  SDRAM_bank,
   output logic [ROW_W-1:0]   SDRAM_addr,
   output logic [COL_W-1:0]   SDRAM_col,
   input  logic               rd_data_valid,
   input  logic [15:0]        rd_data,
   output logic [2:0][7:0]    pix_rgb,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic               pix_last,
   output logic               busy,
   output logic               frame_done,
   output logic               overflow
);

   localparam int HALF     = BURST_LEN / 2;
   localparam int NUM_REQS = 2 * FRAME_PIXELS / BURST_LEN;
   localparam int RW       = $clog2(NUM_REQS + 1);
   localparam int OW       = $clog2(FIFO_DEPTH + 1);
   localparam int PW       = $clog2(FRAME_PIXELS + 1);
   localparam int CRW      = OW + 2;
   localparam logic [RW-1:0] NUM_REQS_C = RW'(NUM_REQS);
   localparam logic [PW-1:0] LAST_PIX_C = PW'(FRAME_PIXELS - 1);
   localparam logic [OW-1:0] HALF_C     = OW'(HALF);

   rd_state_e          state_q, state_d;
   logic [LADDR_W-1:0] addr_q, addr_d;
   logic [RW-1:0]      acked_q, acked_d;
   logic [OW-1:0]      out_q, out_d;       // pixels requested but not yet written to the FIFO
   logic [PW-1:0]      pcnt_q, pcnt_d;     // pixels handed off this frame
   logic               rd_req_q, rd_req_d;
   logic               tog_q, tog_d;
   sdram_word_t        w0_q, w0_d;
   logic               stg_q, stg_d;       // completed pixel waiting for its FIFO write
   pixel_t             stg_pix_q, stg_pix_d;
   logic               ovf_q, ovf_d;

   logic               start_go, ack, word_go, pix_hs, last_hs, credit_ok;
   logic               fifo_empty, fifo_full;
   logic [OW-1:0]      fifo_count;
   sdram_laddr_t       laddr;

   sdram_rd_fifo #(.DEPTH(FIFO_DEPTH), .CW(OW)) u_fifo (
      .clk     (SDRAM_CLK),
      .rst_n   (reset_n),
      .wr_en   (stg_q),
      .wr_data (stg_pix_q),
      .rd_en   (pix_ready),
      .rd_data (pix_rgb),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_count)
   );

   assign pix_valid  = !fifo_empty;
   assign pix_last   = pix_valid && (pcnt_q == LAST_PIX_C);
   assign rd_req     = rd_req_q;
   assign overflow   = ovf_q;
   assign laddr      = sdram_laddr_t'(addr_q);
   assign SDRAM_bank = laddr.bank;
   assign SDRAM_addr = laddr.row;
   assign SDRAM_col  = laddr.col;

   // FSM: state register
   always_ff @(posedge SDRAM_CLK or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      last_hs = pix_valid && pix_ready && pix_last;
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_FETCH;
         ST_FETCH: if (last_hs) state_d = ST_DONE;
                   else if (acked_q == NUM_REQS_C) state_d = ST_DRAIN;
         ST_DRAIN: if (last_hs) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy       = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
      frame_done = (state_q == ST_DONE);
   end

   // Request engine, pixel assembler and counters
   always_comb begin
      start_go  = (state_q == ST_IDLE) && start;
      ack       = rd_req_q && rd_ack;
      word_go   = rd_data_valid && ((state_q == ST_FETCH) || (state_q == ST_DRAIN));
      pix_hs    = pix_valid && pix_ready;
      addr_d    = addr_q;
      acked_d   = acked_q;
      out_d     = out_q;
      pcnt_d    = pcnt_q;
      tog_d     = tog_q;
      w0_d      = w0_q;
      stg_d     = 1'b0;
      stg_pix_d = stg_pix_q;
      ovf_d     = ovf_q;
      if (start_go) begin
         addr_d  = frame_base;
         acked_d = '0;
         out_d   = '0;
         pcnt_d  = '0;
         tog_d   = 1'b0;
         ovf_d   = 1'b0;
      end else begin
         if (ack) begin
            addr_d  = addr_q + LADDR_W'(BURST_LEN);
            acked_d = acked_q + RW'(1);
         end
         // Guard against underflow when unsolicited data completes a pixel.
         out_d = out_q + (ack ? HALF_C : '0) - ((stg_q && (out_q != '0)) ? OW'(1) : '0);
         if (stg_q && fifo_full) ovf_d = 1'b1;
         if (pix_hs) pcnt_d = pcnt_q + PW'(1);
         if (word_go) begin
            if (!tog_q) begin
               w0_d  = rd_data;
               tog_d = 1'b1;
            end else begin
               tog_d     = 1'b0;
               stg_d     = 1'b1;
               stg_pix_d = make_pixel(w0_q, rd_data);
            end
         end
      end
      // Credit uses next-cycle occupancy: out_d already holds this ack and the
      // staged pixel's decrement; stg_q accounts for that pixel entering the FIFO.
      credit_ok = (CRW'(out_d) + CRW'(fifo_count) + CRW'(stg_q) + CRW'(HALF))
                  <= CRW'(FIFO_DEPTH);
      if (rd_req_q && !rd_ack) rd_req_d = 1'b1;
      else rd_req_d = (state_q == ST_FETCH) && (acked_d < NUM_REQS_C) && credit_ok;
   end

   always_ff @(posedge SDRAM_CLK or negedge reset_n) begin
      if (!reset_n) begin
         addr_q    <= '0;
         acked_q   <= '0;
         out_q     <= '0;
         pcnt_q    <= '0;
         rd_req_q  <= 1'b0;
         tog_q     <= 1'b0;
         w0_q      <= '0;
         stg_q     <= 1'b0;
         stg_pix_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         addr_q    <= addr_d;
         acked_q   <= acked_d;
         out_q     <= out_d;
         pcnt_q    <= pcnt_d;
         rd_req_q  <= rd_req_d;
         tog_q     <= tog_d;
         w0_q      <= w0_d;
         stg_q     <= stg_d;
         stg_pix_q <= stg_pix_d;
         ovf_q     <= ovf_d;
      end
   end

endmodule

// File: tb/tb_sdram_frame_reader.sv
// tb_sdram_frame_reader: randomized bench for sdram_frame_reader with an SDRAM
// controller model, a request-address scoreboard and a pixel scoreboard.
`timescale 1ns/1ps
module tb_sdram_frame_reader;

   localparam int FP   = 16;
   localparam int BL   = 4;
   localparam int FD   = 8;
   localparam int NREQ = 2 * FP / BL;

   logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0;
   logic        rd_ack = 1'b0, rd_data_valid = 1'b0, pix_ready = 1'b0;
   logic [23:0] frame_base = '0;
   logic [15:0] rd_data = '0;
   logic        rd_req, pix_valid, pix_last, busy, frame_done, overflow;
   logic [1:0]  bank;
   logic [12:0] row;
   logic [8:0]  col;
   logic [2:0][7:0] pix_rgb;

   sdram_frame_reader #(.FRAME_PIXELS(FP), .BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
      .SDRAM_CLK(clk), .reset_n(reset_n), .start(start), .frame_base(frame_base),
      .rd_req(rd_req), .rd_ack(rd_ack), .SDRAM_bank(bank), .SDRAM_addr(row),
      .SDRAM_col(col), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
      .pix_rgb(pix_rgb), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_last(pix_last), .busy(busy), .frame_done(frame_done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // stimulus knobs
   int          ack_pct = 100, lat = 3, rdy_pct = 100;
   bit          fixed_data = 1'b0;
   logic [15:0] seed;

   typedef struct { int due; logic [15:0] data; } word_t;
   word_t       rq[$];         // words the controller model still has to return
   logic [23:0] exp_req[$];    // expected request addresses, in order
   logic [24:0] exp_pix[$];    // expected {last, B, G, R}
   int          acks = 0, hs = 0;
   bit          done_exp = 1'b0;
   logic [23:0] ctl_a;

   // SDRAM content model
   function automatic logic [15:0] memword(input logic [23:0] a);
      logic [31:0] h;
      if (fixed_data) return a[0] ? 16'h0033 : 16'h2211;
      h = ({8'h0, a} ^ {16'h0, seed}) * 32'h9E3779B1;
      return h[31:16];
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // SDRAM controller model: accepts requests randomly, returns one word per cycle
   initial forever begin
      @(posedge clk); #1;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
         rd_data_valid = 1'b1;
         rd_data       = rq[0].data;
         void'(rq.pop_front());
      end else begin
         rd_data_valid = 1'b0;
         rd_data       = '0;
      end
      rd_ack = rd_req && reset_n && ($urandom_range(99) < ack_pct);
      if (rd_ack) begin
         ctl_a = {bank, row, col};
         chk("req_in_budget", 32'(exp_req.size() > 0), 1);
         if (exp_req.size() > 0) chk("req_addr", ctl_a, exp_req.pop_front());
         acks++;
         for (int w = 0; w < BL; w++) rq.push_back('{cyc + lat, memword(ctl_a + 24'(w))});
      end
   end

   // display-side ready driver
   initial forever begin
      @(posedge clk); #1;
      pix_ready = ($urandom_range(99) < rdy_pct);
   end

   // monitor: pixel scoreboard, credit rule, frame_done timing
   initial forever begin
      @(negedge clk);
      if (reset_n) begin
         if (frame_done || done_exp) chk("frame_done_busy", {frame_done, busy}, {done_exp, 1'b0});
         done_exp = 1'b0;
         if (rd_req)
            chk("credit", 32'(((acks - (rd_ack ? 1 : 0)) * 2 - hs + BL / 2) <= FD), 1);
         if (pix_valid) begin
            chk("pix_pending", 32'(exp_pix.size() != 0), 1);
            if (exp_pix.size() != 0) begin
               chk("pixel", {pix_last, pix_rgb}, exp_pix[0]);
               if (pix_ready) begin
                  done_exp = exp_pix[0][24];
                  void'(exp_pix.pop_front());
                  hs++;
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [23:0] base);
      frame_base = base;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic begin_frame(input logic [23:0] base);
      logic [15:0] w0, w1;
      acks = 0; hs = 0;
      for (int k = 0; k < NREQ; k++) exp_req.push_back(base + 24'(k * BL));
      for (int n = 0; n < FP; n++) begin
         w0 = memword(base + 24'(2 * n));
         w1 = memword(base + 24'(2 * n + 1));
         exp_pix.push_back({n == FP - 1, w1[7:0], w0[15:8], w0[7:0]});
      end
      pulse_start(base);
      chk("busy_after_start", busy, 1);
   endtask

   // returns at the negedge of the frame_done cycle
   task automatic wait_done();
      int i;
      for (i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (frame_done) break;
      end
      chk("frame_in_time", 32'(i < 3000), 1);
   endtask

   task automatic end_frame();
      chk("reqs_consumed", exp_req.size(), 0);
      chk("pixels_consumed", exp_pix.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_rd_req"}, rd_req, 0);
      chk({nm, "_addr"}, {bank, row, col}, 0);
      chk({nm, "_pix_valid"}, pix_valid, 0);
      chk({nm, "_pix_last"}, pix_last, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_frame_done"}, frame_done, 0);
      chk({nm, "_overflow"}, overflow, 0);
      chk({nm, "_pix_rgb"}, pix_rgb, 0);
   endtask

   initial begin
      int i;
      seed = 16'($urandom);
      reset_n = 1'b0;
      tick(3);
      chk_reset_vals("reset");
      reset_n = 1'b1;
      tick(2);

      // basic frame: fixed words, immediate ack, latency 3
      fixed_data = 1'b1; ack_pct = 100; lat = 3; rdy_pct = 100;
      begin_frame(24'h0);
      wait_done();
      chk("basic_overflow", overflow, 0);
      end_frame();
      fixed_data = 1'b0;

      // random frames
      for (int t = 0; t < 4; t++) begin
         ack_pct = $urandom_range(100, 30);
         lat     = $urandom_range(6, 1);
         rdy_pct = $urandom_range(100, 20);
         begin_frame(24'($urandom));
         wait_done();
         end_frame();
      end

      // backpressure: requests stop once the FIFO's worth is stored or owed
      ack_pct = 100; lat = 3; rdy_pct = 0;
      begin_frame(24'($urandom));
      tick(60);
      chk("bp_acks", acks, FD / (BL / 2));
      chk("bp_rd_req", rd_req, 0);
      chk("bp_overflow", overflow, 0);
      chk("bp_pix_valid", pix_valid, 1);
      rdy_pct = 100;
      wait_done();
      end_frame();

      // address wrap past 24'hFFFFFF
      ack_pct = 50; lat = 2; rdy_pct = 70;
      begin_frame(24'hFFFFF8);
      wait_done();
      end_frame();

      // start during FETCH and during DONE is ignored
      ack_pct = 80; lat = 2; rdy_pct = 80;
      begin_frame(24'($urandom));
      tick(3);
      pulse_start(24'($urandom));
      chk("fetch_start_busy", busy, 1);
      wait_done();
      chk("reqs_consumed", exp_req.size(), 0);
      frame_base = 24'($urandom);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_start_ignored", busy, 0);
      begin_frame(24'($urandom));
      wait_done();
      end_frame();

      // reset while a burst is in flight
      ack_pct = 100; lat = 3; rdy_pct = 100;
      begin_frame(24'($urandom));
      for (i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rd_req && rq.size() > 0) break;
      end
      chk("rst_window_found", 32'(i < 100), 1);
      reset_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      exp_req.delete(); exp_pix.delete();
      @(posedge clk); #1;
      reset_n = 1'b1;
      for (i = 0; i < 50 && rq.size() > 0; i++) tick(1);
      tick(3);
      chk("stray_fifo_empty", pix_valid, 0);
      chk("stray_idle", busy, 0);
      begin_frame(24'($urandom));
      wait_done();
      end_frame();

      // overflow: unsolicited pairs while the FIFO is full
      ack_pct = 100; lat = 2; rdy_pct = 0;
      begin_frame(24'($urandom));
      tick(50);
      chk("ovf_pre", overflow, 0);
      for (int k = 0; k < 8; k++) rq.push_back('{cyc, 16'($urandom)});
      tick(20);
      chk("ovf_set", overflow, 1);
      rdy_pct = 100;
      wait_done();
      end_frame();
      chk("ovf_sticky", overflow, 1);
      begin_frame(24'($urandom));
      chk("ovf_cleared", overflow, 0);
      wait_done();
      end_frame();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sdram_frame_reader.md
# sdram_frame_reader

Read-side counterpart of the HDMI ingest writer. It fetches a stored frame from SDRAM through burst read requests to the SDRAM controller, reassembles 24-bit RGB pixels from 16-bit SDRAM words, and streams them with valid/ready to the voxel display driver. A credit-limited request engine guarantees that returned data always fits the internal pixel FIFO.

## Interface
Parameters:
- FRAME_PIXELS, 16384: pixels per frame. 2·FRAME_PIXELS must be a multiple of BURST_LEN.
- BURST_LEN, 8: 16-bit words per read request. Must be even and ≥2.
- FIFO_DEPTH, 32: pixel FIFO entries. Must be a power of two and ≥ BURST_LEN/2.

Ports:
- SDRAM_CLK  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to read a frame; sampled only in IDLE.
- frame_base  in  24  linear word address of pixel 0, laid out as {bank[1:0], row[12:0], col[8:0]}; captured on start.
- rd_req  out  1  burst read request.
- rd_ack  in  1  controller accepts the request in the cycle where rd_req && rd_ack.
- SDRAM_bank  out  2  burst bank.
- SDRAM_addr  out  13  burst row.
- SDRAM_col  out  9  burst column.
- rd_data_valid  in  1  one returned word per cycle.
- rd_data  in  16  returned word.
- pix_rgb  out  [2:0][7:0]  pixel, {B,G,R}.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  display driver accepts the pixel.
- pix_last  out  1  marks the final pixel of the frame; qualified by pix_valid.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- overflow  out  1  sticky error flag; cleared by reset or start.

## Operation
- Word format:
  - Word 0 = {G, R}.
  - Word 1 = {8'h00, B}.
  - Pixel n occupies words frame_base + 2n and frame_base + 2n + 1.
- FSM states:
  - IDLE: on start, capture frame_base into the address counter, clear counters and overflow, go to FETCH.
  - FETCH: issue bursts while credit allows. When all 2·FRAME_PIXELS/BURST_LEN requests have been acknowledged, go to DRAIN.
  - DRAIN: wait until all returned words are received and all pixels are handed off, then go to DONE.
  - DONE: one cycle; assert frame_done; go to IDLE.
- Credit rule: rd_req may be high only if (outstanding_pixels + fifo_count + BURST_LEN/2) ≤ FIFO_DEPTH.
  - outstanding_pixels increases by BURST_LEN/2 on each acknowledge.
  - outstanding_pixels decreases by 1 on each completed word pair.
- Request handshake:
  - Once raised, rd_req and the address outputs are held until rd_ack.
  - rd_req stays high back-to-back across bursts if credit allows.
- Address counter:
  - 24-bit; advances by BURST_LEN on acknowledge.
  - Wraps modulo 2^24, carrying col → row → bank naturally.
- Pixel assembler:
  - A word toggle selects word 0 or word 1.
  - Word 0 is latched.
  - Word 1 completes the pixel and writes it to the FIFO.
- Overflow: rd_data_valid in IDLE or DONE is ignored. A word that would complete a pixel while the FIFO is full is dropped and sets overflow.
- pix_last: asserted with the FRAME_PIXELS-th pixel, which is tracked by an output pixel counter.
- start while busy is ignored, including during DONE.
- Reset values: rd_req=0, address outputs=0, pix_valid=0, pix_last=0, busy=0, frame_done=0, overflow=0, pix_rgb=0. The FSM returns to IDLE and the FIFO empties.
- Reset asserted mid-frame abandons the frame; outstanding controller data arriving afterwards is ignored by the IDLE rule.

## Timing
- busy rises the cycle after start is accepted.
- rd_req rises 1 cycle after entering FETCH.
- Acknowledge advances the address on the next edge.
- A pixel is written to the FIFO on the edge after its word 1 is received.
- The FIFO is show-ahead: pix_valid is high in the following cycle, 2 cycles after word 1.
- pix_rgb and pix_last are stable while pix_valid && !pix_ready.
- One pixel per cycle maximum at the output.
- frame_done is high in the cycle after the last pixel handshake. busy falls in that same cycle.

## Structure
- Package sdram_frame_pkg:
  - pixel_t (packed [2:0][7:0]).
  - sdram_word_t (16 bits).
  - sdram_laddr_t, a struct {bank, row, col}.
  - FSM state enum.
  - Field-width constants (2/13/9).
- Sub-module sdram_rd_fifo: synchronous show-ahead FIFO of pixel_t with count output, same clock and reset.

## Test plan
Unless stated, FRAME_PIXELS=16, BURST_LEN=4, FIFO_DEPTH=8.
- Basic frame: base=0, immediate acknowledge, data latency 3, words 16'h2211 and 16'h0033 → 8 requests at col 0,4,…,28; 16 pixels with R=11 G=22 B=33; pix_last on pixel 16; frame_done one cycle later.
- Backpressure: pix_ready=0 throughout → requests stop once 8 pixels are stored or owed; overflow=0; release pix_ready → frame completes.
- Wrap: base=24'hFFFFF8 → requests at FFFFF8, FFFFFC, 000000, …; bank=3, row=1FFF, col=1F8 on the first request.
- Overlapping start: start pulsed during FETCH and during DONE → ignored; start the cycle after DONE → new frame begins.
- Reset mid-burst: reset_n low while rd_req is high with 2 words outstanding → all outputs go to reset values immediately; stray rd_data_valid afterwards leaves the FIFO empty; a subsequent start reads a correct frame.
- Overflow: inject 4 unsolicited word pairs while the FIFO is full → overflow=1; pixels already in the FIFO are unchanged; overflow clears on the next start.
